branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Execute-stage branch resolution for the RV32I pipeline. Carries each fetched instruction's BTB prediction (hit, taken, target) through the F/D and D/E pipeline registers and compares it with the actual outcome computed in Execute. It drives the BTB update port, the front-end redirect and the F/D flush, and keeps branch and mispredict statistics. It is the write-side partner of the fetch-side BTB lookup.

## Interface
- d_width, 32, PC/data width
- CNT_WIDTH, 32, width of each statistics counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_F_valid  in  1  a real instruction is in Fetch this cycle
- i_F_PC  in  d_width  Fetch PC
- i_F_hit_btb  in  1  BTB hit for i_F_PC
- i_F_jump  in  1  BTB taken bit for i_F_PC
- i_F_PC_target  in  d_width  BTB predicted target
- i_stall_FD  in  1  hold F/D register; D/E register loads a bubble
- i_stall_E  in  1  hold F/D and D/E registers (whole front end frozen)
- i_E_is_branch  in  1  Execute instruction is a conditional branch, JAL or JALR
- i_E_taken  in  1  actual direction (always 1 for JAL/JALR)
- i_E_PC_branch  in  d_width  actual target
- o_update_btb  out  1  BTB write strobe
- o_E_PC_cur  out  d_width  BTB write index/tag PC (= E-stage PC)
- o_E_PC_branch  out  d_width  BTB write target
- o_jump  out  1  BTB write taken bit
- o_redirect  out  1  front end must load o_PC_redirect
- o_PC_redirect  out  d_width  corrected next PC
- o_flush  out  1  kill instructions in F and D
- o_cnt_branch  out  CNT_WIDTH  resolved branches
- o_cnt_mispredict  out  CNT_WIDTH  mispredictions

## Operation
- Per stage (D, E), the unit holds: valid, PC, pred_taken = hit & jump, pred_target, hit, and done (E only).
- Advance priority, highest first: rst > o_flush > i_stall_E > i_stall_FD > normal.
  - rst or o_flush: clear D and E valid.
  - i_stall_E: hold both stages.
  - i_stall_FD: hold D; E loads a bubble (valid=0).
  - Normal: D<=F, E<=D, done<=0.
- Resolution is active when E.valid & !E.done:
  - Branch: mispredict = (pred_taken != i_E_taken) | (pred_taken & i_E_taken & pred_target != i_E_PC_branch).
  - Non-branch: mispredict = pred_taken (BTB alias).
  - Redirect target: o_PC_redirect = i_E_taken&i_E_is_branch ? i_E_PC_branch : E.PC+4, modulo 2^d_width.
- On mispredict: o_redirect = o_flush = 1.
- BTB write: o_update_btb = active & ((i_E_is_branch & (!E.hit | mispredict)) | (!i_E_is_branch & pred_taken)).
  - Branch write: o_jump = i_E_taken, o_E_PC_branch = i_E_PC_branch.
  - Non-branch alias write: o_jump = 0, o_E_PC_branch = E.PC+4.
- done is set at the edge after an active cycle if i_stall_E holds E, so a frozen instruction redirects, updates and counts exactly once.
- Counters:
  - o_cnt_branch increments on active & i_E_is_branch.
  - o_cnt_mispredict increments on active & mispredict.
  - Both saturate at all-ones.

## Timing
- Prediction reaches E two unstalled edges after Fetch.
- Redirect, flush and update outputs are combinational from E-stage registers and E inputs, valid in the same cycle. The BTB write lands at the next edge.
- Counters update at the edge ending the active cycle.
- Reset values: all valid/done 0, all outputs 0, counters 0.
- Reset mid-stall discards everything.
- Flush and stall in the same cycle: flush wins.

## Structure
- Shared package holds the opcode-independent constant PC_STEP = 4 and the stage-record layout (valid, PC, pred_taken, pred_target, hit), which the hazard unit also uses.
- One natural sub-module: pred_stage_reg, a single stage register with hold, bubble and clear controls, instantiated twice.

## Test plan
- BTB miss, taken branch at 0x100 to 0x180 -> o_redirect=1, o_PC_redirect=0x180, o_update_btb=1, o_jump=1, o_cnt_mispredict=1.
- Hit, pred taken to 0x180, actual taken to 0x180 -> no redirect, no update, o_cnt_branch increments only.
- Hit, pred taken, actual not-taken at 0x200 -> o_PC_redirect=0x204, o_jump=0, D/E valid cleared at next edge.
- Non-branch at 0x300 with aliased taken hit -> redirect to 0x304, update with o_jump=0, target 0x304; o_cnt_branch unchanged.
- Mispredicting branch held 3 cycles by i_stall_E -> o_redirect/o_update_btb high for first cycle only, counter +1.
- Both counters preloaded near all-ones via forced mispredicts -> stay at all-ones; rst asserted mid-run -> counters and outputs 0 next cycle.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// Shared definitions for branch resolution: PC step and the per-stage prediction record.
// The hazard unit uses the same record layout.
package branch_resolve_unit_pkg;

    localparam int unsigned PC_STEP = 4;
    localparam int unsigned XLEN    = 32;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
        logic            hit;
    } stage_rec_t;

    // Stage payload without the valid bit: {pc, pred_taken, pred_target, hit}
    function automatic int stage_payload_width(input int pc_w);
        return 2 * pc_w + 2;
    endfunction

endpackage

// File: rtl/pred_stage_reg.sv
// One pipeline stage of carried BTB prediction: valid bit plus packed payload.
// Priority: rst > clear > hold > load (bubble loads with valid forced low).
module pred_stage_reg
    import branch_resolve_unit_pkg::*;
#(
    parameter int PC_W = 32,
    localparam int PW  = stage_payload_width(PC_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clear,
    input  logic          i_hold,
    input  logic          i_bubble,
    input  logic          i_valid,
    input  logic [PW-1:0] i_payload,
    output logic          o_valid,
    output logic [PW-1:0] o_payload
);

    logic          r_valid;
    logic [PW-1:0] r_payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (!i_hold) begin
            r_valid   <= i_valid & ~i_bubble;
            r_payload <= i_payload;
        end
    end

    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: compares carried BTB predictions with actual outcome,
// drives BTB write, redirect and flush, and keeps saturating branch/mispredict counters.
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int d_width   = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_F_valid,
    input  logic [d_width-1:0]   i_F_PC,
    input  logic                 i_F_hit_btb,
    input  logic                 i_F_jump,
    input  logic [d_width-1:0]   i_F_PC_target,
    input  logic                 i_stall_FD,
    input  logic                 i_stall_E,
    input  logic                 i_E_is_branch,
    input  logic                 i_E_taken,
    input  logic [d_width-1:0]   i_E_PC_branch,
    output logic                 o_update_btb,
    output logic [d_width-1:0]   o_E_PC_cur,
    output logic [d_width-1:0]   o_E_PC_branch,
    output logic                 o_jump,
    output logic                 o_redirect,
    output logic [d_width-1:0]   o_PC_redirect,
    output logic                 o_flush,
    output logic [CNT_WIDTH-1:0] o_cnt_branch,
    output logic [CNT_WIDTH-1:0] o_cnt_mispredict
);

    localparam int PW = stage_payload_width(d_width);
    localparam logic [d_width-1:0] W_STEP = d_width'(PC_STEP);

    logic [PW-1:0]      w_f_payload;
    logic [PW-1:0]      w_d_payload;
    logic [PW-1:0]      w_e_payload;
    logic               w_d_valid;
    logic               w_e_valid;
    logic [d_width-1:0] w_e_pc;
    logic [d_width-1:0] w_e_pred_target;
    logic [d_width-1:0] w_e_pc_next;
    logic               w_e_pred_taken;
    logic               w_e_hit;
    logic               w_active;
    logic               w_mispredict_raw;
    logic               w_mispredict;
    logic               w_update;

    logic                 r_e_done;
    logic [CNT_WIDTH-1:0] r_cnt_branch;
    logic [CNT_WIDTH-1:0] r_cnt_mispredict;

    assign w_f_payload = {i_F_PC, i_F_hit_btb & i_F_jump, i_F_PC_target, i_F_hit_btb};

    pred_stage_reg #(.PC_W(d_width)) u_stage_d (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_mispredict),
        .i_hold    (i_stall_E | i_stall_FD),
        .i_bubble  (1'b0),
        .i_valid   (i_F_valid),
        .i_payload (w_f_payload),
        .o_valid   (w_d_valid),
        .o_payload (w_d_payload)
    );

    pred_stage_reg #(.PC_W(d_width)) u_stage_e (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_mispredict),
        .i_hold    (i_stall_E),
        .i_bubble  (i_stall_FD),
        .i_valid   (w_d_valid),
        .i_payload (w_d_payload),
        .o_valid   (w_e_valid),
        .o_payload (w_e_payload)
    );

    assign w_e_pc          = w_e_payload[PW-1 -: d_width];
    assign w_e_pred_taken  = w_e_payload[d_width+1];
    assign w_e_pred_target = w_e_payload[d_width:1];
    assign w_e_hit         = w_e_payload[0];
    assign w_e_pc_next     = w_e_pc + W_STEP;

    assign w_active = w_e_valid & ~r_e_done;

    // A non-branch with a taken prediction is a BTB alias and always mispredicts.
    always_comb begin
        w_mispredict_raw = w_e_pred_taken;
        if (i_E_is_branch) begin
            w_mispredict_raw = (w_e_pred_taken != i_E_taken) |
                               (w_e_pred_taken & i_E_taken & (w_e_pred_target != i_E_PC_branch));
        end
    end

    assign w_mispredict = w_active & w_mispredict_raw;
    assign w_update     = w_active & ((i_E_is_branch & (~w_e_hit | w_mispredict_raw)) |
                                      (~i_E_is_branch & w_e_pred_taken));

    assign o_redirect    = w_mispredict;
    assign o_flush       = w_mispredict;
    assign o_PC_redirect = !w_mispredict ? '0 :
                           (i_E_taken & i_E_is_branch) ? i_E_PC_branch : w_e_pc_next;
    assign o_update_btb  = w_update;
    assign o_jump        = w_update & i_E_is_branch & i_E_taken;
    assign o_E_PC_branch = !w_update ? '0 : (i_E_is_branch ? i_E_PC_branch : w_e_pc_next);
    assign o_E_PC_cur    = w_e_pc;

    // done keeps a frozen instruction from acting again while i_stall_E holds it
    always_ff @(posedge clk) begin
        if (rst || w_mispredict) begin
            r_e_done <= 1'b0;
        end else if (i_stall_E) begin
            r_e_done <= r_e_done | w_active;
        end else begin
            r_e_done <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_branch     <= '0;
            r_cnt_mispredict <= '0;
        end else begin
            if (w_active && i_E_is_branch && (r_cnt_branch != '1)) begin
                r_cnt_branch <= r_cnt_branch + CNT_WIDTH'(1);
            end
            if (w_mispredict && (r_cnt_mispredict != '1)) begin
                r_cnt_mispredict <= r_cnt_mispredict + CNT_WIDTH'(1);
            end
        end
    end

    assign o_cnt_branch     = r_cnt_branch;
    assign o_cnt_mispredict = r_cnt_mispredict;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vector table, stall/saturation/reset sequences,
// and randomized traffic against a behavioural pipeline model.
module tb_branch_resolve_unit;

    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_v, f_h, f_j, s_fd, s_e, e_br, e_tk;
    logic [31:0] f_pc, f_tgt, e_pcb;

    logic          o_update_btb, o_jump, o_redirect, o_flush;
    logic [31:0]   o_E_PC_cur, o_E_PC_branch, o_PC_redirect;
    logic [CW-1:0] o_cnt_branch, o_cnt_mispredict;

    int n_cmp = 0;
    int n_bad = 0;

    branch_resolve_unit #(.d_width(32), .CNT_WIDTH(CW)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_F_valid        (f_v),
        .i_F_PC           (f_pc),
        .i_F_hit_btb      (f_h),
        .i_F_jump         (f_j),
        .i_F_PC_target    (f_tgt),
        .i_stall_FD       (s_fd),
        .i_stall_E        (s_e),
        .i_E_is_branch    (e_br),
        .i_E_taken        (e_tk),
        .i_E_PC_branch    (e_pcb),
        .o_update_btb     (o_update_btb),
        .o_E_PC_cur       (o_E_PC_cur),
        .o_E_PC_branch    (o_E_PC_branch),
        .o_jump           (o_jump),
        .o_redirect       (o_redirect),
        .o_PC_redirect    (o_PC_redirect),
        .o_flush          (o_flush),
        .o_cnt_branch     (o_cnt_branch),
        .o_cnt_mispredict (o_cnt_mispredict)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit fv, input logic [31:0] fpc, input bit fh, input bit fj,
                         input logic [31:0] ftg, input bit sfd, input bit se,
                         input bit br, input bit tk, input logic [31:0] pcb);
        f_v = fv; f_pc = fpc; f_h = fh; f_j = fj; f_tgt = ftg;
        s_fd = sfd; s_e = se; e_br = br; e_tk = tk; e_pcb = pcb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input bit rd, input logic [31:0] pcr, input bit upd,
                            input bit jmp, input logic [31:0] tgt, input int cb, input int cm);
        chk({tag, ".redirect"}, 32'(o_redirect), 32'(rd));
        chk({tag, ".flush"}, 32'(o_flush), 32'(rd));
        chk({tag, ".pc_redirect"}, o_PC_redirect, pcr);
        chk({tag, ".update"}, 32'(o_update_btb), 32'(upd));
        chk({tag, ".jump"}, 32'(o_jump), 32'(jmp));
        chk({tag, ".btb_target"}, o_E_PC_branch, tgt);
        chk({tag, ".cnt_branch"}, 32'(o_cnt_branch), 32'(cb));
        chk({tag, ".cnt_mispredict"}, 32'(o_cnt_mispredict), 32'(cm));
    endtask

    // Behavioural model: each stage is a record; advance follows the stated priority.
    typedef struct {
        bit          v;
        logic [31:0] pc;
        bit          pt;
        logic [31:0] tgt;
        bit          hit;
    } mrec_t;

    mrec_t md, me;
    bit    mdone;
    int    mcb, mcm;

    task automatic model_reset();
        md = '{0, 32'h0, 0, 32'h0, 0};
        me = '{0, 32'h0, 0, 32'h0, 0};
        mdone = 0; mcb = 0; mcm = 0;
    endtask

    task automatic mcyc(input string tag);
        bit          act, mp, upd, ejmp;
        logic [31:0] epcr, etgt;
        @(negedge clk);
        act = me.v && !mdone;
        if (e_br) mp = (me.pt != e_tk) || (me.pt && e_tk && me.tgt != e_pcb);
        else      mp = me.pt;
        mp   = act && mp;
        upd  = act && (e_br ? (!me.hit || mp) : me.pt);
        epcr = mp ? ((e_tk && e_br) ? e_pcb : me.pc + 32'd4) : 32'h0;
        ejmp = upd && e_br && e_tk;
        etgt = upd ? (e_br ? e_pcb : me.pc + 32'd4) : 32'h0;
        chk_outs(tag, mp, epcr, upd, ejmp, etgt, mcb, mcm);
        if (act) chk({tag, ".pc_cur"}, o_E_PC_cur, me.pc);
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (act && e_br && mcb < CMAX) mcb++;
            if (mp && mcm < CMAX) mcm++;
            if (mp) begin
                md.v = 0; me.v = 0; mdone = 0;
            end else if (s_e) begin
                mdone = mdone || act;
            end else if (s_fd) begin
                me.v = 0; mdone = 0;
            end else begin
                me = md;
                md = '{f_v, f_pc, f_h && f_j, f_tgt, f_h};
                mdone = 0;
            end
        end
        #1;
    endtask

    typedef struct {
        bit fv; logic [31:0] fpc; bit fh; bit fj; logic [31:0] ftg;
        bit br; bit tk; logic [31:0] pcb;
        bit x_rd; logic [31:0] x_pcr; bit x_upd; bit x_jmp; logic [31:0] x_tgt; logic [31:0] x_cur;
        int x_cb; int x_cm;
    } vec_t;

    vec_t tbl [12];

    initial begin
        tbl[0]  = '{1, 32'h100, 0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 0};
        tbl[1]  = '{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   0, 0};
        tbl[2]  = '{1, 32'h200, 0, 0, 32'h0,   1, 1, 32'h180, 1, 32'h180, 1, 1, 32'h180, 32'h100, 0, 0};
        tbl[3]  = '{1, 32'h100, 1, 1, 32'h180, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 1};
        tbl[4]  = '{1, 32'h200, 1, 1, 32'h280, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 1};
        tbl[5]  = '{1, 32'h900, 1, 1, 32'h990, 1, 1, 32'h180, 0, 32'h0,   0, 0, 32'h0,   32'h0,   1, 1};
        tbl[6]  = '{0, 32'h0,   0, 0, 32'h0,   1, 0, 32'h280, 1, 32'h204, 1, 0, 32'h280, 32'h200, 2, 1};
        tbl[7]  = '{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   3, 2};
        tbl[8]  = '{1, 32'h300, 1, 1, 32'h500, 0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   3, 2};
        tbl[9]  = '{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   3, 2};
        tbl[10] = '{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   1, 32'h304, 1, 0, 32'h304, 32'h300, 3, 2};
        tbl[11] = '{0, 32'h0,   0, 0, 32'h0,   0, 0, 32'h0,   0, 32'h0,   0, 0, 32'h0,   32'h0,   3, 3};

        // Reset state, with branch inputs active to show outputs stay quiet
        rst = 1'b1;
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h55);
        tick(); tick();
        @(negedge clk);
        chk_outs("reset", 0, 32'h0, 0, 0, 32'h0, 0, 0);
        chk("reset.pc_cur", o_E_PC_cur, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].fv, tbl[i].fpc, tbl[i].fh, tbl[i].fj, tbl[i].ftg, 0, 0,
                  tbl[i].br, tbl[i].tk, tbl[i].pcb);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), tbl[i].x_rd, tbl[i].x_pcr, tbl[i].x_upd,
                     tbl[i].x_jmp, tbl[i].x_tgt, tbl[i].x_cb, tbl[i].x_cm);
            if (tbl[i].x_upd || tbl[i].x_rd)
                chk($sformatf("vec%0d.pc_cur", i), o_E_PC_cur, tbl[i].x_cur);
            @(posedge clk); #1;
        end

        // Correctly predicted miss (not taken) frozen 3 cycles: one update, one count
        drive(1, 32'h600, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 0, 32'h680);
        @(negedge clk);
        chk_outs("holdA0", 0, 32'h0, 1, 0, 32'h680, 3, 3);
        chk("holdA0.pc_cur", o_E_PC_cur, 32'h600);
        @(posedge clk); #1;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk_outs($sformatf("holdA%0d", k), 0, 32'h0, 0, 0, 32'h0, 4, 3);
            @(posedge clk); #1;
        end
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk_outs("holdA3", 0, 32'h0, 0, 0, 32'h0, 4, 3);
        @(posedge clk); #1;

        // Mispredicting branch frozen 3 cycles: redirect/update in first cycle only
        drive(1, 32'h400, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0); tick();
        drive(0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 1, 32'h480);
        @(negedge clk);
        chk_outs("holdB0", 1, 32'h480, 1, 1, 32'h480, 4, 3);
        @(posedge clk); #1;
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            chk_outs($sformatf("holdB%0d", k), 0, 32'h0, 0, 0, 32'h0, 5, 4);
            @(posedge clk); #1;
        end
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk_outs("holdB3", 0, 32'h0, 0, 0, 32'h0, 5, 4);
        @(posedge clk); #1;

        // Randomized traffic against the model, starting from a fresh reset
        rst = 1'b1;
        tick(); tick();
        model_reset();
        rst = 1'b0;
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 3) != 0,
                  32'h1000 + 32'(4 * $urandom_range(0, 7)),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                  32'h2000 + 32'(4 * $urandom_range(0, 3)),
                  $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  32'h2000 + 32'(4 * $urandom_range(0, 3)));
            rst = ($urandom_range(0, 149) == 0);
            mcyc("rand");
        end
        rst = 1'b0;

        // Forced mispredicts drive both counters into saturation
        for (int n = 0; n < 20; n++) begin
            drive(1, 32'h700, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0); mcyc("sat");
            drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);   mcyc("sat");
            drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 1, 1, 32'h780); mcyc("sat");
        end
        chk("sat.cnt_branch_max", 32'(o_cnt_branch), 32'(CMAX));
        chk("sat.cnt_mispredict_max", 32'(o_cnt_mispredict), 32'(CMAX));

        // Reset while a mispredicting branch sits stalled in E discards everything
        drive(1, 32'h800, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0); mcyc("rstmid");
        drive(0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0);   mcyc("rstmid");
        drive(0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 1, 32'h880);
        rst = 1'b1;
        mcyc("rstmid");
        rst = 1'b0;
        @(negedge clk);
        chk_outs("rstmid.after", 0, 32'h0, 0, 0, 32'h0, 0, 0);
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
